// File: rtl/reset_sequencer_if.sv
// Reset sequencer bundle: lock/retrigger inputs and per-channel reset/status outputs.
interface reset_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              lock_i;
    logic              reset_i;
    logic [NUM_CH-1:0] reset_o;
    logic              done_o;
    logic              busy_o;
    logic [1:0]        state_o;

    modport master (
        input  lock_i,
        input  reset_i,
        output reset_o,
        output done_o,
        output busy_o,
        output state_o
    );

    modport slave (
        output lock_i,
        output reset_i,
        input  reset_o,
        input  done_o,
        input  busy_o,
        input  state_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// Lock-gated multi-channel reset sequencer: waits for stable lock,
// holds all resets, then releases channels in order, STAGGER cycles apart.
module reset_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int DELAY   = 10,
    parameter int WIDTH   = 50,
    parameter int STAGGER = 8,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                async_reset_n,
    reset_sequencer_if.master   bus
);
    localparam logic [1:0] S_DELAY   = 2'd0;
    localparam logic [1:0] S_WIDTH   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] DLY  = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] WID  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STG  = CNT_W'(STAGGER);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
    localparam logic [CH_W-1:0]  LAST = CH_W'(NUM_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              done_q, busy_q;

    // Saturating increment so a long stall can never wrap past a compare.
    assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        unique case (1'b1)
            (state_q == S_DELAY): begin
                if (!bus.lock_i || bus.reset_i) begin
                    cnt_d = '0;
                end else if (cnt_inc >= DLY) begin
                    state_d = S_WIDTH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            (state_q == S_WIDTH),
            (state_q == S_RELEASE),
            (state_q == S_DONE): begin
                if (!bus.lock_i || bus.reset_i) begin
                    state_d = S_DELAY;
                    cnt_d   = '0;
                    ch_d    = '0;
                    rst_d   = '1;
                end else if (state_q == S_WIDTH) begin
                    if (cnt_inc >= WID) begin
                        rst_d[0] = 1'b0;
                        cnt_d    = '0;
                        ch_d     = CH_W'(1);
                        state_d  = (NUM_CH == 1) ? S_DONE : S_RELEASE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (state_q == S_RELEASE) begin
                    if (cnt_inc >= STG) begin
                        rst_d[ch_q] = 1'b0;
                        cnt_d       = '0;
                        if (ch_q == LAST) begin
                            state_d = S_DONE;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = S_DELAY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= S_DELAY;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d != S_DONE);
        end
    end

    assign bus.reset_o = rst_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = busy_q;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 4-channel instance plus a
// minimal 1-channel instance, checked against hand-computed edge numbers.
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edg;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_CH(4)) b ();
    reset_sequencer_if #(.NUM_CH(1)) s ();

    reset_sequencer dut (
        .clk           (clk),
        .async_reset_n (rst_n),
        .bus           (b)
    );

    reset_sequencer #(
        .NUM_CH  (1),
        .DELAY   (1),
        .WIDTH   (1),
        .STAGGER (8)
    ) dut1 (
        .clk           (clk),
        .async_reset_n (rst_n),
        .bus           (s)
    );

    // Edge 1 is the first rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edg <= 0;
        else        edg <= edg + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic at(input int n);
        int g = 0;
        while (edg < n && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (edg != n) chk("edge_timeout", edg, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_reset_o", 32'(b.reset_o), 32'hF);
        chk("rst_done", 32'(b.done_o), 0);
        chk("rst_busy", 32'(b.busy_o), 1);
        chk("rst_state", 32'(b.state_o), 0);
        b.lock_i  = 1'b1;
        b.reset_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        b.lock_i  = 1'b1;
        b.reset_i = 1'b0;
        s.lock_i  = 1'b1;
        s.reset_i = 1'b0;

        // Test 1 + 4 on the default instance, test 6 on the 1-channel one.
        do_reset();
        chk("t6_rst", 32'(s.reset_o), 1);
        at(1);
        chk("t1_e1", 32'(b.reset_o), 32'hF);
        chk("t6_e1_state", 32'(s.state_o), 1);
        chk("t6_e1_rst", 32'(s.reset_o), 1);
        chk("t6_e1_done", 32'(s.done_o), 0);
        at(2);
        chk("t6_e2_rst", 32'(s.reset_o), 0);
        chk("t6_e2_done", 32'(s.done_o), 1);
        s.reset_i = 1'b1;
        at(3);
        chk("t6_e3_rst", 32'(s.reset_o), 1);
        chk("t6_e3_state", 32'(s.state_o), 0);
        chk("t6_e3_done", 32'(s.done_o), 0);
        at(10);
        chk("t6_e10_state", 32'(s.state_o), 0);
        chk("t6_e10_rst", 32'(s.reset_o), 1);
        at(30);
        chk("t1_e30_state", 32'(b.state_o), 1);
        at(59);
        chk("t1_e59", 32'(b.reset_o), 32'hF);
        at(60);
        chk("t1_e60", 32'(b.reset_o), 32'hE);
        chk("t1_e60_state", 32'(b.state_o), 2);
        at(67);
        chk("t1_e67", 32'(b.reset_o), 32'hE);
        at(68);
        chk("t1_e68", 32'(b.reset_o), 32'hC);
        at(76);
        chk("t1_e76", 32'(b.reset_o), 32'h8);
        at(83);
        chk("t1_e83_done", 32'(b.done_o), 0);
        at(84);
        chk("t1_e84", 32'(b.reset_o), 0);
        chk("t1_e84_done", 32'(b.done_o), 1);
        chk("t1_e84_busy", 32'(b.busy_o), 0);
        chk("t1_e84_state", 32'(b.state_o), 3);
        at(100);
        b.reset_i = 1'b1;
        at(101);
        b.reset_i = 1'b0;
        chk("t4_e101", 32'(b.reset_o), 32'hF);
        chk("t4_e101_done", 32'(b.done_o), 0);
        chk("t4_e101_state", 32'(b.state_o), 0);
        at(161);
        chk("t4_e161", 32'(b.reset_o), 32'hE);
        at(184);
        chk("t4_e184", 32'(b.reset_o), 32'h8);
        chk("t4_e184_done", 32'(b.done_o), 0);
        at(185);
        chk("t4_e185", 32'(b.reset_o), 0);
        chk("t4_e185_done", 32'(b.done_o), 1);

        // Test 2: lock low for the sample at edge 6 restarts DELAY.
        do_reset();
        at(5);
        b.lock_i = 1'b0;
        at(6);
        b.lock_i = 1'b1;
        at(65);
        chk("t2_e65", 32'(b.reset_o), 32'hF);
        at(66);
        chk("t2_e66", 32'(b.reset_o), 32'hE);

        // Test 3: lock loss mid-RELEASE.
        do_reset();
        at(70);
        chk("t3_e70", 32'(b.reset_o), 32'hC);
        b.lock_i = 1'b0;
        at(71);
        chk("t3_e71", 32'(b.reset_o), 32'hF);
        chk("t3_e71_done", 32'(b.done_o), 0);
        chk("t3_e71_state", 32'(b.state_o), 0);
        b.lock_i = 1'b1;
        at(130);
        chk("t3_e130", 32'(b.reset_o), 32'hF);
        at(131);
        chk("t3_e131", 32'(b.reset_o), 32'hE);

        // Test 5: async reset between edges mid-WIDTH.
        do_reset();
        at(30);
        chk("t5_e30_state", 32'(b.state_o), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_rst", 32'(b.reset_o), 32'hF);
        chk("t5_async_state", 32'(b.state_o), 0);
        chk("t5_async_busy", 32'(b.busy_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        at(59);
        chk("t5_e59", 32'(b.reset_o), 32'hF);
        at(60);
        chk("t5_e60", 32'(b.reset_o), 32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
